ppu_spr_fetch: RTL

- Consumer side of the sprite pipeline: reads the 8-sprite secondary OAM written by sprite evaluation during x_idx 257–320.
- Fetches each sprite's pattern bytes from VRAM and loads 8 sprite output units.
- During the next visible scanline (x_idx 1–256), shifts units out to produce the sprite pixel, priority bit and sprite-0 opaque flag for the PPU pixel mux.

---
 rtl/ppu_spr_fetch_if.sv | 17 +
 rtl/ppu_spr_fetch.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ppu_spr_fetch_if.sv
// Secondary-OAM and VRAM read bus used by the sprite fetch/render unit.
interface ppu_spr_fetch_if;
  logic [4:0]  s_oam_addr;
  logic [7:0]  s_oam_data;
  logic [15:0] VRAM_addr;
  logic [7:0]  VRAM_data_in;

  modport master (
    output s_oam_addr, VRAM_addr,
    input  s_oam_data, VRAM_data_in
  );

  modport slave (
    input  s_oam_addr, VRAM_addr,
    output s_oam_data, VRAM_data_in
  );
endinterface

// File: rtl/ppu_spr_fetch.sv
// Sprite pattern fetch (dots 257-320) and 8-unit sprite shifter (dots 1-256).
// The priority output is named spr_priority because priority is an SV keyword.
module ppu_spr_fetch #(
  parameter int unsigned NUM_SPR      = 8,
  parameter int unsigned FETCH_START  = 257,
  parameter int unsigned RENDER_START = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x_idx,
  input  logic [9:0]        scanline,
  input  logic              spr_pt_addr,
  input  logic [3:0]        spr_count,
  input  logic              spr0_in_range,
  ppu_spr_fetch_if.master   bus,
  output logic [3:0]        pixel,
  output logic              spr_priority,
  output logic              spr0_pixel
);

  localparam logic [9:0] FETCH_FIRST  = 10'(FETCH_START);
  localparam logic [9:0] FETCH_LAST   = 10'(FETCH_START + NUM_SPR * 8 - 1);
  localparam logic [9:0] RENDER_FIRST = 10'(RENDER_START);
  localparam logic [9:0] RENDER_LAST  = 10'(RENDER_START + 255);

  logic [9:0] fx;
  logic [2:0] slot;
  logic [2:0] phase;
  logic       in_fetch;
  logic       in_render;
  logic [9:0] y_idx;
  logic [7:0] y_diff;
  logic [2:0] row;
  logic       slot_valid;

  logic [7:0] y_lat, tile_lat, attr_lat, x_lat, lo_lat;
  logic       fetch_abort;

  logic [7:0] u_lo  [NUM_SPR];
  logic [7:0] u_hi  [NUM_SPR];
  logic [7:0] u_x   [NUM_SPR];
  logic [1:0] u_pal [NUM_SPR];
  logic       u_pri [NUM_SPR];
  logic       u_s0  [NUM_SPR];

  logic [3:0] win_pix;
  logic       win_pri;
  logic       win_s0;
  logic       found;
  logic [1:0] cand;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int unsigned k = 0; k < 8; k++) r[k] = b[7 - k];
    return r;
  endfunction

  assign fx        = x_idx - FETCH_FIRST;
  assign slot      = fx[5:3];
  assign phase     = fx[2:0];
  assign in_fetch  = (x_idx >= FETCH_FIRST) && (x_idx <= FETCH_LAST);
  assign in_render = (scanline >= 10'd1) && (scanline <= 10'd240) &&
                     (x_idx >= RENDER_FIRST) && (x_idx <= RENDER_LAST);
  assign y_idx     = scanline - 10'd1;
  assign y_diff    = y_idx[7:0] - y_lat;
  // attr arrives on s_oam_data in the same phase the row is needed
  assign row       = y_diff[2:0] ^ {3{bus.s_oam_data[7]}};
  // 4-bit compare means spr_count above 8 simply marks every slot valid
  assign slot_valid = ({1'b0, slot} < spr_count);

  always_comb begin
    win_pix = '0;
    win_pri = 1'b0;
    win_s0  = 1'b0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned u = 0; u < NUM_SPR; u++) begin
      cand = (u_x[u] == '0) ? {u_hi[u][7], u_lo[u][7]} : 2'b00;
      if (!found && cand != 2'b00) begin
        found   = 1'b1;
        win_pix = {u_pal[u], cand};
        win_pri = u_pri[u];
        win_s0  = u_s0[u];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.s_oam_addr <= '0;
      bus.VRAM_addr  <= '0;
      pixel          <= '0;
      spr_priority   <= 1'b0;
      spr0_pixel     <= 1'b0;
      y_lat          <= '0;
      tile_lat       <= '0;
      attr_lat       <= '0;
      x_lat          <= '0;
      lo_lat         <= '0;
      fetch_abort    <= 1'b1;
      for (int unsigned u = 0; u < NUM_SPR; u++) begin
        u_lo[u]  <= '0;
        u_hi[u]  <= '0;
        u_x[u]   <= '0;
        u_pal[u] <= '0;
        u_pri[u] <= 1'b0;
        u_s0[u]  <= 1'b0;
      end
    end else begin
      // a reset inside the window kills the rest of that window's fetch
      if (!in_fetch) fetch_abort <= 1'b0;

      if (in_render) begin
        pixel        <= win_pix;
        spr_priority <= win_pri;
        spr0_pixel   <= win_s0;
      end else begin
        pixel        <= '0;
        spr_priority <= 1'b0;
        spr0_pixel   <= 1'b0;
      end

      if (in_render) begin
        for (int unsigned u = 0; u < NUM_SPR; u++) begin
          if (u_x[u] != '0) begin
            u_x[u] <= u_x[u] - 8'd1;
          end else begin
            u_lo[u] <= {u_lo[u][6:0], 1'b0};
            u_hi[u] <= {u_hi[u][6:0], 1'b0};
          end
        end
      end else if (in_fetch && !fetch_abort) begin
        case (phase)
          3'd0: bus.s_oam_addr <= {slot, 2'b00};
          3'd1: begin
            y_lat          <= bus.s_oam_data;
            bus.s_oam_addr <= {slot, 2'b01};
          end
          3'd2: begin
            tile_lat       <= bus.s_oam_data;
            bus.s_oam_addr <= {slot, 2'b10};
          end
          3'd3: begin
            attr_lat       <= bus.s_oam_data;
            bus.s_oam_addr <= {slot, 2'b11};
            bus.VRAM_addr  <= {3'b000, spr_pt_addr, tile_lat, 1'b0, row};
          end
          3'd4: x_lat <= bus.s_oam_data;
          3'd5: begin
            lo_lat           <= bus.VRAM_data_in;
            bus.VRAM_addr[3] <= 1'b1;
          end
          3'd7: begin
            if (slot_valid) begin
              u_lo[slot] <= attr_lat[6] ? rev8(lo_lat) : lo_lat;
              u_hi[slot] <= attr_lat[6] ? rev8(bus.VRAM_data_in) : bus.VRAM_data_in;
            end else begin
              u_lo[slot] <= '0;
              u_hi[slot] <= '0;
            end
            u_x[slot]   <= x_lat;
            u_pal[slot] <= attr_lat[1:0];
            u_pri[slot] <= attr_lat[5];
            u_s0[slot]  <= (slot == 3'd0) && spr0_in_range;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
